instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle instruction sequencer for the 32-bit processor. It fetches an instruction word over an instruction-memory handshake, latches it for the decoder, and steps the datapath through the EXEC, MEM and WB phases with one-cycle strobes. It also maintains the program counter, a retired-instruction counter and a sticky illegal-opcode flag. It sits between instruction/data memory and the decoder/ALU/register-file datapath.

## Interface
Parameters:
- DWIDTH, 32, instruction/data word width
- AWIDTH, 16, program counter width (word address)
- CWIDTH, 32, retired-instruction counter width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  sequencer enable; sampled at instruction boundaries only
- imem_req  out  1  instruction fetch request
- imem_addr  out  AWIDTH  fetch address (= pc)
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  DWIDTH  fetched instruction word
- ir  out  DWIDTH  latched instruction, feeds decoder
- alu_en  out  1  one-cycle ALU execute strobe
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req
- dmem_ack  in  1  data access complete
- rf_we  out  1  one-cycle register-file write strobe
- pc  out  AWIDTH  program counter
- instret  out  CWIDTH  retired-instruction count
- busy  out  1  state != IDLE
- illegal  out  1  sticky; set on unsupported fx

Decided: one clock (clk); reset rst_n is asynchronous and active-low.

## Operation
- fx = ir[18:15]. Classes:
  - NOP: 1111
  - ALU: 0000 ADD, 0011 SUB, 1000 AND, 1001 OR, 1011 NOT, 1010 XOR, 1101 SLL, 0010 MOV
  - LOAD: 0100
  - STORE: 0110
  - ILLEGAL: 0001, 0101, 0111, 1100, 1110
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB.
- IDLE: run=1 → FETCH; otherwise hold.
- FETCH: imem_req=1 and imem_addr=pc every cycle until imem_ack. On ack, ir <= imem_rdata → DECODE.
- DECODE: one cycle; classify fx.
  - ILLEGAL: set illegal, retire.
  - NOP: retire.
  - Otherwise → EXEC.
- EXEC: alu_en=1 for one cycle.
  - ALU → WB.
  - LOAD/STORE → MEM.
- MEM: dmem_req=1 and dmem_we=(STORE) held until dmem_ack.
  - On ack, LOAD → WB; STORE retires.
- WB: rf_we=1 for one cycle; retire.
- Retire (same edge as leaving DECODE/MEM/WB):
  - pc <= pc+1, wrapping from all-ones to 0.
  - instret <= instret+1, wrapping.
  - Next state: FETCH if run=1, else IDLE.
- ILLEGAL and NOP retire, count in instret, and never assert alu_en, dmem_req or rf_we.
- illegal clears only on reset.
- run=0 mid-instruction: the current instruction completes; stop happens at the retire boundary.
- Acks with the matching req low are ignored. imem_ack outside FETCH and dmem_ack outside MEM have no effect.

## Timing
- Reset (async assert): state=IDLE; pc, instret, ir=0; all strobes/requests=0; illegal=0; busy=0. Any outstanding request is abandoned immediately.
- Outputs are registered or pure decodes of state: req, alu_en and rf_we are functions of state only, with no input-to-output combinational path.
- Latency (FETCH entry to retire edge), zero-wait memory (ack in first req cycle):
  - NOP/ILLEGAL: 2 cycles
  - ALU: 4 cycles
  - STORE: 4 cycles
  - LOAD: 5 cycles
  - Each wait cycle on ack adds 1.
- Back-to-back: FETCH of the next instruction occurs the cycle after retire, with the updated pc.
- IDLE → FETCH takes one cycle after run is sampled high.

## Structure
- Package seq_pkg holds:
  - fx code localparams (FX_ADD … FX_NOP)
  - state enum seq_state_t
  - class enum instr_class_t
- One combinational sub-module, instr_classify: fx in, instr_class_t out. Reused by the decoder for consistency.
- Everything else (FSM, pc, instret, ir, illegal) lives in instr_sequencer.

## Test plan
- Reset then run=1, zero-wait imem returning fx=0000 ADD: imem_req at cycle 1, alu_en at cycle 3, rf_we at cycle 4; pc=1, instret=1 afterwards.
- LOAD with dmem_ack delayed 3 cycles: dmem_req high 4 cycles with dmem_we=0; rf_we pulses once after ack; pc increments by 1.
- STORE: dmem_we=1 during MEM; rf_we never asserted; instret increments.
- fx=0101: illegal=1 and stays 1; no alu_en, dmem_req or rf_we; pc advances; the next ADD executes normally.
- pc=all-ones retiring an instruction → pc=0; run dropped during MEM → instruction completes, state goes IDLE, busy=0.
- rst_n asserted mid-FETCH with imem_req high → all outputs 0 within the same cycle (async); after release, resumes at pc=0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and fx opcode constants for the multi-cycle instruction sequencer.
package seq_pkg;

    localparam logic [3:0] FX_ADD   = 4'b0000;
    localparam logic [3:0] FX_SUB   = 4'b0011;
    localparam logic [3:0] FX_AND   = 4'b1000;
    localparam logic [3:0] FX_OR    = 4'b1001;
    localparam logic [3:0] FX_NOT   = 4'b1011;
    localparam logic [3:0] FX_XOR   = 4'b1010;
    localparam logic [3:0] FX_SLL   = 4'b1101;
    localparam logic [3:0] FX_MOV   = 4'b0010;
    localparam logic [3:0] FX_LOAD  = 4'b0100;
    localparam logic [3:0] FX_STORE = 4'b0110;
    localparam logic [3:0] FX_NOP   = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB
    } seq_state_t;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_ILLEGAL
    } instr_class_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction- and data-memory handshake bundle between the sequencer and memory.
interface instr_sequencer_if #(
    parameter int AWIDTH = 16,
    parameter int DWIDTH = 32
);
    logic              imem_req;
    logic [AWIDTH-1:0] imem_addr;
    logic              imem_ack;
    logic [DWIDTH-1:0] imem_rdata;
    logic              dmem_req;
    logic              dmem_we;
    logic              dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_ack, imem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_ack, imem_rdata, dmem_ack
    );
endinterface

// File: rtl/instr_classify.sv
// Maps the fx field of an instruction onto its execution class.
module instr_classify
    import seq_pkg::*;
(
    input  logic [3:0]   fx,
    output instr_class_t cls
);

    always_comb begin
        cls = CLS_ILLEGAL;
        case (fx)
            FX_ADD, FX_SUB, FX_AND, FX_OR,
            FX_NOT, FX_XOR, FX_SLL, FX_MOV: cls = CLS_ALU;
            FX_LOAD:                        cls = CLS_LOAD;
            FX_STORE:                       cls = CLS_STORE;
            FX_NOP:                         cls = CLS_NOP;
            default:                        cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with pc, retired count and sticky illegal flag.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 16,
    parameter int CWIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    instr_sequencer_if.master   mem,
    output logic [DWIDTH-1:0]   ir,
    output logic                alu_en,
    output logic                rf_we,
    output logic [AWIDTH-1:0]   pc,
    output logic [CWIDTH-1:0]   instret,
    output logic                busy,
    output logic                illegal
);

    seq_state_t   state, state_next;
    instr_class_t cls;
    logic         retire;

    // ir is stable from DECODE until retire, so its class can be decoded live
    instr_classify u_classify (
        .fx  (ir[18:15]),
        .cls (cls)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            pc      <= '0;
            instret <= '0;
            ir      <= '0;
            illegal <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_FETCH && mem.imem_ack)
                ir <= mem.imem_rdata;
            if (state == ST_DECODE && cls == CLS_ILLEGAL)
                illegal <= 1'b1;
            if (retire) begin
                pc      <= pc + AWIDTH'(1);
                instret <= instret + CWIDTH'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        retire     = 1'b0;
        case (state)
            ST_IDLE:   if (run) state_next = ST_FETCH;
            ST_FETCH:  if (mem.imem_ack) state_next = ST_DECODE;
            ST_DECODE: begin
                if (cls == CLS_NOP || cls == CLS_ILLEGAL) retire = 1'b1;
                else                                      state_next = ST_EXEC;
            end
            ST_EXEC:   state_next = (cls == CLS_ALU) ? ST_WB : ST_MEM;
            ST_MEM: begin
                if (mem.dmem_ack) begin
                    if (cls == CLS_LOAD) state_next = ST_WB;
                    else                 retire = 1'b1;
                end
            end
            ST_WB:     retire = 1'b1;
            default:   state_next = ST_IDLE;
        endcase
        // the stop/continue decision is taken only at an instruction boundary
        if (retire)
            state_next = run ? ST_FETCH : ST_IDLE;
    end

    assign mem.imem_req  = (state == ST_FETCH);
    assign mem.imem_addr = pc;
    assign mem.dmem_req  = (state == ST_MEM);
    assign mem.dmem_we   = (state == ST_MEM) && (cls == CLS_STORE);
    assign alu_en        = (state == ST_EXEC);
    assign rf_we         = (state == ST_WB);
    assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer against a per-instruction timeline model.
module tb_instr_sequencer;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int CW = 6;

    localparam int C_NOP = 0, C_ALU = 1, C_LOAD = 2, C_STORE = 3, C_ILL = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run;
    logic [DW-1:0] ir;
    logic          alu_en, rf_we, busy, illegal;
    logic [AW-1:0] pc;
    logic [CW-1:0] instret;

    always #5 clk = ~clk;

    instr_sequencer_if #(.AWIDTH(AW), .DWIDTH(DW)) mem_bus ();

    instr_sequencer #(.DWIDTH(DW), .AWIDTH(AW), .CWIDTH(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .mem     (mem_bus),
        .ir      (ir),
        .alu_en  (alu_en),
        .rf_we   (rf_we),
        .pc      (pc),
        .instret (instret),
        .busy    (busy),
        .illegal (illegal)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_pc, m_ret;
    bit          m_ill;
    logic [31:0] m_ir;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_class(input logic [3:0] fx);
        case (fx)
            4'b1111: return C_NOP;
            4'b0000, 4'b0011, 4'b1000, 4'b1001,
            4'b1011, 4'b1010, 4'b1101, 4'b0010: return C_ALU;
            4'b0100: return C_LOAD;
            4'b0110: return C_STORE;
            default: return C_ILL;
        endcase
    endfunction

    function automatic logic [31:0] mk(input logic [3:0] fx);
        logic [31:0] w;
        w = $urandom;
        w[18:15] = fx;
        return w;
    endfunction

    // acks and run are randomized in cycles where the design must ignore them
    task automatic noise();
        mem_bus.imem_ack   = 1'($urandom_range(0, 1));
        mem_bus.imem_rdata = $urandom;
        mem_bus.dmem_ack   = 1'($urandom_range(0, 1));
        run                = 1'($urandom_range(0, 1));
    endtask

    task automatic check_cycle(input bit ireq, input bit alu, input bit dreq,
                               input bit we, input bit rf, input bit bsy);
        check("imem_req", mem_bus.imem_req, ireq);
        if (ireq) check("imem_addr", mem_bus.imem_addr, m_pc);
        check("alu_en", alu_en, alu);
        check("dmem_req", mem_bus.dmem_req, dreq);
        if (dreq) check("dmem_we", mem_bus.dmem_we, we);
        check("rf_we", rf_we, rf);
        check("busy", busy, bsy);
        check("pc", pc, m_pc);
        check("instret", instret, m_ret);
        check("illegal", illegal, m_ill);
        check("ir", ir, m_ir);
    endtask

    task automatic check_reset();
        check("rst_imem_req", mem_bus.imem_req, 0);
        check("rst_dmem_req", mem_bus.dmem_req, 0);
        check("rst_alu_en", alu_en, 0);
        check("rst_rf_we", rf_we, 0);
        check("rst_busy", busy, 0);
        check("rst_pc", pc, 0);
        check("rst_instret", instret, 0);
        check("rst_ir", ir, 0);
        check("rst_illegal", illegal, 0);
    endtask

    task automatic model_reset();
        m_pc = 0; m_ret = 0; m_ill = 0; m_ir = '0;
    endtask

    task automatic model_retire(input bit ill);
        m_pc  = (m_pc + 1) % (1 << AW);
        m_ret = (m_ret + 1) % (1 << CW);
        if (ill) m_ill = 1;
    endtask

    // Starts at a negedge in IDLE; leaves at the negedge of the first FETCH cycle.
    task automatic idle_then_go(input int n);
        for (int i = 0; i < n; i++) begin
            check_cycle(0, 0, 0, 0, 0, 0);
            noise();
            run = (i == n - 1);
            @(negedge clk);
        end
    endtask

    // Starts at a negedge in the first FETCH cycle; leaves right after the retire edge.
    task automatic do_instr(input logic [31:0] word, input int iw, input int dw, input bit run_after);
        int c;
        c = ref_class(word[18:15]);
        for (int k = 0; k <= iw; k++) begin
            check_cycle(1, 0, 0, 0, 0, 1);
            noise();
            mem_bus.imem_ack = (k == iw);
            if (k == iw) mem_bus.imem_rdata = word;
            @(negedge clk);
        end
        m_ir = word;
        check_cycle(0, 0, 0, 0, 0, 1);
        noise();
        if (c == C_NOP || c == C_ILL) begin
            run = run_after;
            @(negedge clk);
            model_retire(c == C_ILL);
            return;
        end
        @(negedge clk);
        check_cycle(0, 1, 0, 0, 0, 1);
        noise();
        @(negedge clk);
        if (c == C_LOAD || c == C_STORE) begin
            for (int j = 0; j <= dw; j++) begin
                check_cycle(0, 0, 1, c == C_STORE, 0, 1);
                noise();
                mem_bus.dmem_ack = (j == dw);
                if (c == C_STORE && j == dw) run = run_after;
                @(negedge clk);
            end
        end
        if (c != C_STORE) begin
            check_cycle(0, 0, 0, 0, 1, 1);
            noise();
            run = run_after;
            @(negedge clk);
        end
        model_retire(0);
    endtask

    initial begin
        bit ra;
        rst_n = 1'b0;
        run = 1'b0;
        mem_bus.imem_ack = 1'b0;
        mem_bus.imem_rdata = '0;
        mem_bus.dmem_ack = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset();
        rst_n = 1'b1;

        // zero-wait ADD straight out of reset
        idle_then_go(1);
        do_instr(mk(4'b0000), 0, 0, 1);
        check("pc_after_add", pc, 1);
        check("instret_after_add", instret, 1);

        do_instr(mk(4'b0100), 1, 3, 1);
        do_instr(mk(4'b0110), 0, 1, 1);
        do_instr(mk(4'b0101), 2, 0, 1);
        check("illegal_set", illegal, 1);
        do_instr(mk(4'b0000), 0, 0, 1);
        check("illegal_sticky", illegal, 1);
        do_instr(mk(4'b1111), 1, 0, 1);

        // run dropped while in MEM: store completes, then the sequencer idles
        do_instr(mk(4'b0110), 0, 2, 0);
        check("busy_after_stop", busy, 0);
        idle_then_go(3);

        for (int i = 0; i < 200; i++) begin
            ra = (i == 199) ? 1'b1 : ($urandom_range(0, 9) != 0);
            do_instr(mk(4'($urandom_range(0, 15))), $urandom_range(0, 3), $urandom_range(0, 3), ra);
            if (!ra) idle_then_go($urandom_range(1, 3));
        end

        // asynchronous reset while a fetch is outstanding
        check_cycle(1, 0, 0, 0, 0, 1);
        noise();
        mem_bus.imem_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle_then_go(1);
        check("resume_addr", mem_bus.imem_addr, 0);
        do_instr(mk(4'b1010), 1, 0, 0);
        check("pc_after_resume", pc, 1);
        check("instret_after_resume", instret, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
